ram_bank_eraser: RTL and testbench

//  AXI4 write master that fills one DDR bank with a fixed pattern on command. Sits directly

---
 rtl/ram_bank_eraser_pkg.sv | 28 ++
 rtl/ram_bank_eraser_wgen.sv | 50 +++++
 rtl/ram_bank_eraser.sv | 161 ++++++++++++++++
 tb/tb_ram_bank_eraser.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bank_eraser_pkg.sv
// Shared encodings for the bank eraser: AXI burst/response codes, FSM states,
// and a helper that sizes counters from their largest value.
package ram_bank_eraser_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } eraser_state_t;

    // Bits needed to hold every value 0..max_val (at least one bit).
    function automatic int unsigned cnt_bits(input logic [63:0] max_val);
        int unsigned bits;
        bits = 1;
        while (bits < 64 && (max_val >> bits) != 64'd0) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/ram_bank_eraser_wgen.sv
// W-beat generator: streams beats of full bursts, never ahead of the number of
// bursts whose address has already been accepted (aw_cnt).
module ram_bank_eraser_wgen
    import ram_bank_eraser_pkg::*;
#(
    parameter int unsigned CW          = 6,
    parameter int unsigned BURST_BEATS = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          run,
    input  logic [CW-1:0] aw_cnt,
    input  logic          wready,
    output logic          wvalid,
    output logic          wlast,
    output logic [CW-1:0] w_cnt
);

    localparam int unsigned     BW        = cnt_bits(64'(BURST_BEATS - 1));
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BURST_BEATS - 1);

    logic [BW-1:0] beat_cnt;
    logic          w_hs;

    // Valid only depends on registered counts, so once raised it can only
    // fall after the handshake that consumes it.
    assign wvalid = run && (w_cnt < aw_cnt);
    assign wlast  = (beat_cnt == LAST_BEAT);
    assign w_hs   = wvalid && wready;

    // Beat counter wraps per burst; completed bursts counted on the last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
            w_cnt    <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
            w_cnt    <= '0;
        end else if (w_hs) begin
            if (wlast) begin
                beat_cnt <= '0;
                w_cnt    <= w_cnt + 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_bank_eraser.sv
// AXI4 write master that fills a DDR bank with a constant pattern using
// full-length INCR bursts, with a cap on bursts awaiting their write response.
//
// state    | meaning
// ST_IDLE  | waiting for erase_ram; erase_idle=1
// ST_RUN   | issuing AW and W traffic, accepting B
// ST_DRAIN | all AW/W sent, waiting for remaining B responses
module ram_bank_eraser
    import ram_bank_eraser_pkg::*;
#(
    parameter int unsigned DW          = 512,
    parameter int unsigned AW          = 64,
    parameter logic [63:0] RAM_BASE    = 64'h0,
    parameter logic [63:0] RAM_SIZE    = 64'h1_0000_0000,
    parameter int unsigned BURST_BEATS = 64,
    parameter logic [31:0] FILL        = 32'hFFFF_FFFF,
    parameter int unsigned MAX_OUTST   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            erase_ram,
    output logic            erase_idle,
    output logic            erase_error,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY
);

    localparam logic [63:0]   BURST_BYTES = 64'(BURST_BEATS) * 64'(DW / 8);
    localparam logic [63:0]   NBURSTS     = RAM_SIZE / BURST_BYTES;
    localparam int unsigned   CW          = cnt_bits(NBURSTS);
    localparam logic [CW-1:0] NB          = CW'(NBURSTS);
    localparam logic [CW-1:0] NB_M1       = CW'(NBURSTS - 64'd1);

    eraser_state_t state, state_nxt;

    logic [CW-1:0] aw_cnt;
    logic [CW-1:0] b_cnt;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] outst;
    logic          start;
    logic          running;
    logic          aw_hs;
    logic          b_hs;
    logic          aw_done;
    logic          w_done;
    logic          b_done;

    assign outst   = aw_cnt - b_cnt;
    assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
    assign b_hs    = M_AXI_BVALID && M_AXI_BREADY;
    assign aw_done = (aw_cnt == NB);
    assign w_done  = (w_cnt == NB);
    // Counting the B accepted this cycle lets the return to idle land the
    // cycle right after the final response.
    assign b_done  = (b_cnt == NB) || (b_hs && (b_cnt == NB_M1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded controls; erase_ram while busy is ignored.
    always_comb begin
        state_nxt    = state;
        start        = 1'b0;
        running      = 1'b0;
        erase_idle   = 1'b0;
        M_AXI_BREADY = 1'b0;
        case (state)
            ST_IDLE: begin
                erase_idle = 1'b1;
                if (erase_ram) begin
                    start     = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                running      = 1'b1;
                M_AXI_BREADY = 1'b1;
                if (aw_done && w_done) begin
                    state_nxt = b_done ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                M_AXI_BREADY = 1'b1;
                if (b_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Burst issue and response accounting; error flag is sticky per erase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_cnt      <= '0;
            b_cnt       <= '0;
            erase_error <= 1'b0;
        end else if (start) begin
            aw_cnt      <= '0;
            b_cnt       <= '0;
            erase_error <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_cnt <= aw_cnt + 1'b1;
            end
            if (b_hs) begin
                b_cnt <= b_cnt + 1'b1;
                if (M_AXI_BRESP != RESP_OKAY) begin
                    erase_error <= 1'b1;
                end
            end
        end
    end

    // AWVALID depends only on registered counts: a B can only widen the window,
    // so valid and address stay put until AWREADY.
    assign M_AXI_AWVALID = running && (aw_cnt < NB) && (64'(outst) < 64'(MAX_OUTST));
    assign M_AXI_AWADDR  = AW'(RAM_BASE) + AW'(aw_cnt) * AW'(BURST_BYTES);
    assign M_AXI_AWLEN   = 8'(BURST_BEATS - 1);
    assign M_AXI_AWSIZE  = 3'(cnt_bits(64'(DW / 8)) - 1);
    assign M_AXI_AWBURST = BURST_INCR;

    assign M_AXI_WDATA   = {(DW / 32){FILL}};
    assign M_AXI_WSTRB   = '1;

    ram_bank_eraser_wgen #(
        .CW          (CW),
        .BURST_BEATS (BURST_BEATS)
    ) u_wgen (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .run    (running),
        .aw_cnt (aw_cnt),
        .wready (M_AXI_WREADY),
        .wvalid (M_AXI_WVALID),
        .wlast  (M_AXI_WLAST),
        .w_cnt  (w_cnt)
    );

endmodule

// File: tb/tb_ram_bank_eraser.sv
// Directed bench for ram_bank_eraser: a behavioural AXI slave with adjustable
// ready/valid rates drives the main instance; a second instance covers
// single-beat bursts.
module tb_ram_bank_eraser;

    localparam int NB   = 32;
    localparam int BB   = 4;
    localparam int OUTS = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // main instance signals
    logic         erase_ram, erase_idle, erase_error;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid, awready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast, wvalid, wready;
    logic [1:0]   bresp;
    logic         bvalid, bready;

    // single-beat instance signals
    logic         erase_ram1, erase_idle1, erase_error1;
    logic [63:0]  awaddr1;
    logic [7:0]   awlen1;
    logic [2:0]   awsize1;
    logic [1:0]   awburst1;
    logic         awvalid1, awready1;
    logic [511:0] wdata1;
    logic [63:0]  wstrb1;
    logic         wlast1, wvalid1, wready1;
    logic [1:0]   bresp1;
    logic         bvalid1, bready1;

    ram_bank_eraser #(
        .DW(512), .AW(64), .RAM_BASE(64'h0), .RAM_SIZE(64'd8192),
        .BURST_BEATS(BB), .FILL(32'hFFFF_FFFF), .MAX_OUTST(OUTS)
    ) dut (
        .clk(clk), .reset(reset), .erase_ram(erase_ram),
        .erase_idle(erase_idle), .erase_error(erase_error),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    ram_bank_eraser #(
        .DW(512), .AW(64), .RAM_BASE(64'h0), .RAM_SIZE(64'd128),
        .BURST_BEATS(1), .FILL(32'hFFFF_FFFF), .MAX_OUTST(OUTS)
    ) dut1 (
        .clk(clk), .reset(reset), .erase_ram(erase_ram1),
        .erase_idle(erase_idle1), .erase_error(erase_error1),
        .M_AXI_AWADDR(awaddr1), .M_AXI_AWLEN(awlen1), .M_AXI_AWSIZE(awsize1),
        .M_AXI_AWBURST(awburst1), .M_AXI_AWVALID(awvalid1), .M_AXI_AWREADY(awready1),
        .M_AXI_WDATA(wdata1), .M_AXI_WSTRB(wstrb1), .M_AXI_WLAST(wlast1),
        .M_AXI_WVALID(wvalid1), .M_AXI_WREADY(wready1),
        .M_AXI_BRESP(bresp1), .M_AXI_BVALID(bvalid1), .M_AXI_BREADY(bready1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // slave knobs set by the sequence
    int aw_rate = 100, w_rate = 100, b_rate = 100;
    int b_budget = 1000;
    int err_burst = -1;
    bit full_tp = 1'b0;
    bit start_req = 1'b0;
    bit start1_req = 1'b0;

    // reference model of the main instance
    int aw_hs, w_beats, wlast_hs, b_hs;
    bit model_busy, model_err;
    bit aw_pend, w_pend, hold_wlast, b_fired;
    logic [63:0] hold_addr;

    // model of the single-beat instance
    int aw1, w1, b1;
    bit busy1, b1_fired;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Slave + scoreboard for the main instance. Outputs are registered-only, so
    // the values seen at the falling edge are what the next rising edge uses.
    initial begin
        erase_ram = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (reset) begin
                aw_hs = 0; w_beats = 0; wlast_hs = 0; b_hs = 0;
                model_busy = 1'b0; model_err = 1'b0;
                aw_pend = 1'b0; w_pend = 1'b0; b_fired = 1'b0;
                erase_ram = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            end else begin
                check_val("erase_idle", erase_idle, !model_busy);
                check_val("erase_error", erase_error, model_err);
                if (aw_pend) begin
                    check_val("awvalid_hold", awvalid, 1);
                    check_val("awaddr_hold", awaddr, hold_addr);
                end
                if (w_pend) begin
                    check_val("wvalid_hold", wvalid, 1);
                    check_val("wlast_hold", wlast, hold_wlast);
                end
                if (wvalid) check_val("w_not_ahead", wlast_hs < aw_hs, 1);
                if (awvalid) begin
                    check_val("aw_outstanding", (aw_hs - b_hs) < OUTS, 1);
                    check_val("aw_total", aw_hs < NB, 1);
                end
                if (full_tp && model_busy && w_beats > 0 && w_beats < NB * BB)
                    check_val("w_no_bubble", wvalid, 1);

                erase_ram = start_req;
                start_req = 1'b0;
                awready = ($urandom_range(0, 99) < aw_rate);
                wready  = ($urandom_range(0, 99) < w_rate);
                if (b_fired) bvalid = 1'b0;
                if (!bvalid && b_budget > 0 && imin(aw_hs, wlast_hs) > b_hs &&
                    $urandom_range(0, 99) < b_rate) begin
                    bvalid = 1'b1;
                    bresp  = (b_hs == err_burst) ? 2'b10 : 2'b00;
                end

                if (awvalid && awready) begin
                    check_val("awaddr", awaddr, 64'(aw_hs) * 64'h100);
                    check_val("awlen", awlen, 3);
                    check_val("awsize", awsize, 6);
                    check_val("awburst", awburst, 1);
                    aw_hs++;
                end
                if (wvalid && wready) begin
                    check_val("wlast", wlast, (w_beats % BB) == BB - 1);
                    check_val("wdata_fill", &wdata, 1);
                    check_val("wstrb_ones", &wstrb, 1);
                    w_beats++;
                    if (wlast) wlast_hs++;
                end
                b_fired = bvalid && bready;
                if (b_fired) begin
                    if (bresp != 2'b00) model_err = 1'b1;
                    b_hs++;
                    b_budget--;
                    if (b_hs == NB) model_busy = 1'b0;
                end
                if (erase_ram && !model_busy) begin
                    model_busy = 1'b1; model_err = 1'b0;
                    aw_hs = 0; w_beats = 0; wlast_hs = 0; b_hs = 0;
                end

                aw_pend    = awvalid && !awready;
                hold_addr  = awaddr;
                w_pend     = wvalid && !wready;
                hold_wlast = wlast;
            end
        end
    end

    // Always-ready slave for the single-beat instance.
    initial begin
        erase_ram1 = 1'b0; awready1 = 1'b1; wready1 = 1'b1; bvalid1 = 1'b0; bresp1 = 2'b00;
        forever begin
            @(negedge clk);
            if (reset) begin
                aw1 = 0; w1 = 0; b1 = 0; busy1 = 1'b0; b1_fired = 1'b0;
                erase_ram1 = 1'b0; bvalid1 = 1'b0;
            end else begin
                check_val("idle1", erase_idle1, !busy1);
                erase_ram1 = start1_req;
                start1_req = 1'b0;
                if (b1_fired) bvalid1 = 1'b0;
                if (!bvalid1 && imin(aw1, w1) > b1) bvalid1 = 1'b1;
                if (awvalid1) begin
                    check_val("awaddr1", awaddr1, 64'(aw1) * 64'h40);
                    check_val("awlen1", awlen1, 0);
                    check_val("awsize1", awsize1, 6);
                    check_val("awburst1", awburst1, 1);
                    aw1++;
                end
                if (wvalid1) begin
                    check_val("wlast1", wlast1, 1);
                    check_val("wdata1", &wdata1, 1);
                    check_val("wstrb1", &wstrb1, 1);
                    w1++;
                end
                b1_fired = bvalid1 && bready1;
                if (b1_fired) begin
                    check_val("bresp1_ok", erase_error1, 0);
                    b1++;
                    if (b1 == 2) busy1 = 1'b0;
                end
                if (erase_ram1 && !busy1) begin
                    busy1 = 1'b1; aw1 = 0; w1 = 0; b1 = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic start_erase();
        int k;
        start_req = 1'b1;
        k = 0;
        while (!model_busy && k < 10) begin tick(1); k++; end
        check_val("start_accepted", model_busy, 1);
    endtask

    task automatic finish_erase(input string tag, input bit exp_err);
        int k;
        k = 0;
        while (model_busy && k < 3000) begin tick(1); k++; end
        check_val({tag, "_timeout"}, model_busy, 0);
        tick(1);
        check_val({tag, "_aw_count"}, aw_hs, NB);
        check_val({tag, "_w_beats"}, w_beats, NB * BB);
        check_val({tag, "_wlast_count"}, wlast_hs, NB);
        check_val({tag, "_b_count"}, b_hs, NB);
        check_val({tag, "_idle"}, erase_idle, 1);
        check_val({tag, "_error"}, erase_error, exp_err);
        check_val({tag, "_awvalid_off"}, awvalid, 0);
        check_val({tag, "_bready_off"}, bready, 0);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        tick(3);
        check_val("rst_idle", erase_idle, 1);
        check_val("rst_error", erase_error, 0);
        check_val("rst_awvalid", awvalid, 0);
        check_val("rst_wvalid", wvalid, 0);
        check_val("rst_bready", bready, 0);
        check_val("rst_idle1", erase_idle1, 1);
        reset = 1'b0;
        tick(2);

        // 1: everything ready, full throughput
        full_tp = 1'b1;
        start_erase();
        finish_erase("t1", 1'b0);
        full_tp = 1'b0;

        // 2: responses withheld -> outstanding cap, one B releases one AW
        b_budget = 0;
        start_erase();
        tick(60);
        check_val("t2_aw_capped", aw_hs, OUTS);
        check_val("t2_awvalid_low", awvalid, 0);
        check_val("t2_w_beats", w_beats, OUTS * BB);
        b_budget = 1;
        tick(20);
        check_val("t2_aw_after_b", aw_hs, OUTS + 1);
        check_val("t2_b_after_b", b_hs, 1);
        b_budget = 1000;
        finish_erase("t2", 1'b0);

        // 3: random stalls on all three channels
        aw_rate = 60; w_rate = 50; b_rate = 40;
        start_erase();
        finish_erase("t3", 1'b0);
        aw_rate = 100; w_rate = 100; b_rate = 100;

        // 4: error response on burst 7, cleared by the next erase
        err_burst = 7;
        start_erase();
        finish_erase("t4", 1'b1);
        err_burst = -1;
        start_erase();
        tick(3);
        check_val("t4_error_cleared", erase_error, 0);
        finish_erase("t4b", 1'b0);

        // 5: re-strobe while busy is ignored
        start_erase();
        k = 0;
        while (aw_hs < 5 && k < 200) begin tick(1); k++; end
        check_val("t5_reached_5", aw_hs >= 5, 1);
        start_req = 1'b1;
        finish_erase("t5", 1'b0);

        // 5b: reset mid-erase
        start_erase();
        k = 0;
        while (aw_hs < 10 && k < 300) begin tick(1); k++; end
        check_val("t5_reached_10", aw_hs >= 10, 1);
        #1 reset = 1'b1;
        #1;
        check_val("t5_rst_idle", erase_idle, 1);
        check_val("t5_rst_awvalid", awvalid, 0);
        check_val("t5_rst_wvalid", wvalid, 0);
        check_val("t5_rst_bready", bready, 0);
        check_val("t5_rst_error", erase_error, 0);
        tick(2);
        reset = 1'b0;
        tick(3);
        check_val("t5_post_idle", erase_idle, 1);
        check_val("t5_post_awvalid", awvalid, 0);

        // 6: single-beat bursts, two of them
        start1_req = 1'b1;
        k = 0;
        while (!busy1 && k < 10) begin tick(1); k++; end
        check_val("t6_started", busy1, 1);
        k = 0;
        while (busy1 && k < 200) begin tick(1); k++; end
        check_val("t6_timeout", busy1, 0);
        tick(1);
        check_val("t6_aw", aw1, 2);
        check_val("t6_w", w1, 2);
        check_val("t6_b", b1, 2);
        check_val("t6_idle", erase_idle1, 1);
        check_val("t6_awvalid_off", awvalid1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
